factor_check_seq: RTL and testbench



---
 rtl/factor_pkg.sv | 14 +
 rtl/factor_mul_core.sv | 55 +++++
 rtl/factor_check_seq.sv | 116 +++++++++++
 tb/tb_factor_check_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/factor_pkg.sv
// Shared types and sizing for the sequential factorization checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package factor_pkg;

    localparam int FACTOR_W_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/factor_mul_core.sv
// Shift-add multiplier datapath: operand registers, 2W-bit accumulator, bit counter.
// Latency: W run cycles after load, one multiplier bit consumed per cycle.
// Backpressure: none internally; the owner holds run low to stall and load only when idle.
module factor_mul_core
    import factor_pkg::*;
#(
    parameter int W = FACTOR_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           run,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   a_reg,
    output logic [W-1:0]   b_reg,
    output logic [2*W-1:0] acc,
    output logic           last
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [CW-1:0]  cnt;
    logic [2*W-1:0] addend;

    // Partial product for the current multiplier bit; zero when that bit is clear.
    always_comb begin
        addend = '0;
        if (b_reg[cnt]) begin
            addend = {{W{1'b0}}, a_reg} << cnt;
        end
    end

    assign last = (cnt == CNT_LAST);

    // Capture operands on load, then accumulate one shifted partial product per run cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (load) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            cnt   <= '0;
        end else if (run) begin
            acc   <= acc + addend;
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/factor_check_seq.sv
// Checks whether two W-bit candidates multiply to a W-bit target as a non-trivial factorization.
// Latency: W+1 cycles from accept to out_valid; one request every W+2 cycles at best.
// Backpressure: result and flags held stable in DONE until out_ready; in_ready low while busy.
module factor_check_seq
    import factor_pkg::*;
#(
    parameter int W = FACTOR_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic [W-1:0]   in_target,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_product,
    output logic           out_overflow,
    output logic           out_trivial,
    output logic           out_ok
);

    state_t         state;
    state_t         state_nxt;
    logic           load;
    logic           run;
    logic           last;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   target_reg;
    logic [2*W-1:0] acc;
    logic           ovf;
    logic           triv;

    factor_mul_core #(
        .W (W)
    ) u_mul_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .run   (run),
        .a     (in_a),
        .b     (in_b),
        .a_reg (a_reg),
        .b_reg (b_reg),
        .acc   (acc),
        .last  (last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs; ready/valid come from state only, never from the peer.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        run       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = MUL;
                end
            end
            MUL: begin
                run = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Target is only needed for the final compare, so it lives beside the flag logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_reg <= '0;
        end else if (load) begin
            target_reg <= in_target;
        end
    end

    // Result flags from registered state only; trivial/ok are masked outside DONE.
    always_comb begin
        ovf          = |acc[2*W-1:W];
        triv         = (a_reg <= W'(1)) | (b_reg <= W'(1));
        out_product  = acc;
        out_overflow = ovf;
        out_trivial  = 1'b0;
        out_ok       = 1'b0;
        if (state == DONE) begin
            out_trivial = triv;
            out_ok      = ~ovf & ~triv & (acc[W-1:0] == target_reg);
        end
    end

endmodule

// File: tb/tb_factor_check_seq.sv
// Directed bench for factor_check_seq at W=10 with hand-computed expected results.
// Latency: measures accept-to-out_valid against W+1.
// Backpressure: holds out_ready low for 20 cycles and checks the result stays frozen.
module tb_factor_check_seq;

    localparam int W = 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic [W-1:0]   in_target = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] out_product;
    logic           out_overflow;
    logic           out_trivial;
    logic           out_ok;

    int checks = 0;
    int errors = 0;

    factor_check_seq #(
        .W (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_target    (in_target),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_product  (out_product),
        .out_overflow (out_overflow),
        .out_trivial  (out_trivial),
        .out_ok       (out_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Present one request, scramble the inputs after the accept edge, wait for out_valid.
    task automatic run_req(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] t, output int lat);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        in_a = a; in_b = b; in_target = t; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = ~a; in_b = a ^ b; in_target = ~t;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic expect_res(input string tag, input logic [2*W-1:0] prod,
                              input logic ovf, input logic triv, input logic ok);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_prod"}, out_product, prod);
        chk({tag, "_ovf"}, out_overflow, ovf);
        chk({tag, "_triv"}, out_trivial, triv);
        chk({tag, "_ok"}, out_ok, ok);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drained"}, out_valid, 1'b0);
    endtask

    initial begin
        int lat;
        logic stable;
        logic [2*W-1:0] hold_prod;
        logic hold_ovf, hold_triv, hold_ok;

        // Reset state.
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_prod", out_product, 0);
        chk("rst_ovf", out_overflow, 1'b0);
        chk("rst_triv", out_trivial, 1'b0);
        chk("rst_ok", out_ok, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Non-trivial factorization with latency check.
        run_req(10'd3, 10'd5, 10'd15, lat);
        chk("lat_3x5", lat, 11);
        chk("busy_in_ready", in_ready, 1'b0);
        expect_res("f3x5", 20'd15, 1'b0, 1'b0, 1'b1);
        consume("f3x5");

        // Trivial factor.
        run_req(10'd1, 10'd15, 10'd15, lat);
        expect_res("triv1x15", 20'd15, 1'b0, 1'b1, 1'b0);
        consume("triv1x15");

        // Overflow with matching low bits.
        run_req(10'd40, 10'd40, 10'd576, lat);
        expect_res("ovf40x40", 20'd1600, 1'b1, 1'b0, 1'b0);
        consume("ovf40x40");

        // Largest operands.
        run_req(10'd1023, 10'd1023, 10'd1, lat);
        expect_res("max", 20'd1046529, 1'b1, 1'b0, 1'b0);
        consume("max");

        // Zero operand.
        run_req(10'd0, 10'd7, 10'd0, lat);
        expect_res("zero", 20'd0, 1'b0, 1'b1, 1'b0);
        consume("zero");

        // Boundary target with backpressure.
        run_req(10'd31, 10'd33, 10'd1023, lat);
        expect_res("b31x33", 20'd1023, 1'b0, 1'b0, 1'b1);
        hold_prod = out_product; hold_ovf = out_overflow;
        hold_triv = out_trivial; hold_ok = out_ok;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || out_product !== hold_prod ||
                out_overflow !== hold_ovf || out_trivial !== hold_triv || out_ok !== hold_ok)
                stable = 1'b0;
        end
        chk("bp_stable", stable, 1'b1);

        // Release with a new request already waiting: not taken on the release edge.
        in_a = 10'd2; in_b = 10'd3; in_target = 10'd6; in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("rel_out_valid", out_valid, 1'b0);
        chk("rel_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 10'd1000; in_b = 10'd999; in_target = 10'd5;
        chk("b2b_accepted", in_ready, 1'b0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("lat_b2b", lat, 11);
        expect_res("b2b2x3", 20'd6, 1'b0, 1'b0, 1'b1);
        consume("b2b2x3");

        // Reset five cycles into MUL aborts the operation.
        in_a = 10'd100; in_b = 10'd100; in_target = 10'd16; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_prod", out_product, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) stable = 1'b0;
        end
        chk("arst_no_result", stable, 1'b1);
        run_req(10'd7, 10'd9, 10'd63, lat);
        chk("lat_7x9", lat, 11);
        expect_res("f7x9", 20'd63, 1'b0, 1'b0, 1'b1);
        consume("f7x9");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
